vx_ag_tcu_fedp_seq: RTL
=======================

# vx_ag_tcu_fedp_seq

Operand sequencer placed directly upstream of the AG-TCU fused dot-product (FEDP) unit. It accepts a stream of K-step dot-product beats over a valid/ready handshake and drives the FEDP's `a_row`/`b_col`/`c_val`/`fmt`/`enable` inputs one beat at a time. It chains each FEDP result back in as the next beat's `c_val`, waiting out the FEDP pipeline latency, and returns the final fp32 accumulation on a valid/ready response port.

## Interface
- `N`, 1: FEDP lanes; XLEN words per beat per operand.
- `LATENCY`, 4: FEDP pipeline depth; legal values are 0 and 4.
- `MAX_STEPS`, 16: beats per request before overflow is flagged; ≥1.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: beat valid.
- `req_ready` out 1: beat accepted when `req_valid && req_ready`.
- `req_a` in N×XLEN: packed A row; 2×fp16 or 2×bf16 per word.
- `req_b` in N×XLEN: packed B column.
- `req_c` in XLEN: fp32 initial accumulator in [31:0]; used on the first beat only.
- `req_fmt_s` in 3: source format (1 = fp16, 2 = bf16); sampled on the first beat.
- `req_fmt_d` in 3: destination format; sampled on the first beat.
- `req_last` in 1: final beat of the request.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: result consumed when `rsp_valid && rsp_ready`.
- `rsp_d` out XLEN: fp32 result, zero-extended.
- `rsp_steps` out $clog2(MAX_STEPS+1): beats accumulated, saturating at MAX_STEPS.
- `rsp_ovf` out 1: more than MAX_STEPS beats were received.
- `fedp_enable` out 1: FEDP pipeline enable.
- `fedp_fmt_s`, `fedp_fmt_d` out 3 each: to FEDP.
- `fedp_a_row`, `fedp_b_col` out N×XLEN: to FEDP.
- `fedp_c_val` out XLEN: to FEDP.
- `fedp_d_val` in XLEN: from FEDP.

## Operation
- States:
  - IDLE: `req_ready` = 1.
  - RUN: waiting on the FEDP.
  - NEXT: `req_ready` = 1, mid-request.
  - RESP: `rsp_valid` = 1.
- IDLE, on handshake:
  - register `req_a`/`req_b` into the FEDP operand registers.
  - `fedp_c_val` ← `req_c`; latch `fmt_s`/`fmt_d`.
  - set `steps` ← 1; set `last_q` ← `req_last`; clear `ovf`.
  - load `cnt` ← LATENCY; go to RUN.
- NEXT, on handshake:
  - same as IDLE, except `fedp_c_val` ← `acc_q` (the previous result), not `req_c`.
  - `req_fmt_*` is ignored; the first beat's format holds for the whole request.
  - `steps` increments, saturating at MAX_STEPS; `ovf` sets when a beat arrives with `steps` == MAX_STEPS.
- RUN:
  - `fedp_enable` = 1.
  - when `cnt` ≠ 0: decrement `cnt`.
  - when `cnt` == 0: `acc_q` ← `fedp_d_val`[31:0]; go to RESP if `last_q`, otherwise go to NEXT.
- RESP: hold `rsp_d` = `acc_q`, `rsp_steps`, and `rsp_ovf` stable until `rsp_ready`; then go to IDLE.
- `fedp_enable` = 0 outside RUN. The frozen FEDP pipe is harmless because every capture follows LATENCY enabled cycles of fresh operands.
- `req_ready` is 0 in RUN and RESP. A `req_valid` asserted there is held off and is not lost.
- The FEDP operand and format outputs hold their values outside RUN.

## Timing
- Handshake at cycle t: the FEDP sees the new operands during t+1; capture happens at the end of cycle t+1+LATENCY.
  - `rsp_valid` first rises in cycle t+2+LATENCY (t+6 for LATENCY = 4).
  - When `req_last` = 0, `req_ready` rises again in cycle t+2+LATENCY.
- Throughput: one beat per LATENCY+2 cycles.
- LATENCY = 0: capture at the end of t+1; response or next-ready in t+2.
- Response with `rsp_ready` already high: `rsp_valid` is high for one cycle; IDLE, with `req_ready` = 1, follows in the next cycle. There is no IDLE-to-RESP bypass.
- Reset values:
  - state IDLE.
  - `rsp_valid` 0, `req_ready` 1 in the first cycle after reset.
  - `fedp_enable` 0; `rsp_d`, `rsp_steps`, `rsp_ovf` 0.
  - FEDP operand and format outputs 0; `cnt` 0.
- Reset in any state: the partial accumulation is discarded and no response is emitted.
- Single-beat request (`req_last` on the first beat): path is IDLE→RUN→RESP.

## Test plan
- N=2, fp16. One beat, `req_last`=1, every A half = 0x3C00 (1.0), every B half = 0x4000 (2.0), `req_c`=0 → `rsp_valid` at t+6 with `rsp_d`=0x41000000 (8.0), `rsp_steps`=1, `rsp_ovf`=0.
- Same beat sent twice, the second with `req_last`=1 → second beat's `fedp_c_val`=0x41000000; `rsp_d`=0x41800000 (16.0); `rsp_steps`=2; second `req_ready` rises at t+6.
- bf16 (fmt_s=2). A halves = 0x3F80, B halves = 0x4040 (3.0), `req_c`=0x3F800000 → `rsp_d`=0x41500000 (13.0).
- Hold `rsp_ready` low 5 cycles in RESP while driving `req_valid` → `rsp_valid`/`rsp_d` stable, `req_ready`=0, no beat accepted, `fedp_enable`=0.
- MAX_STEPS=2, three beats of the first scenario → `rsp_steps`=2, `rsp_ovf`=1, `rsp_d`=0x41C00000 (24.0).
- Assert `reset` in the RUN cycle of the second beat → next cycle IDLE, `req_ready`=1, `rsp_valid`=0. A subsequent single-beat request returns 0x41000000, with no carry-over from the aborted request.

Source files
------------

// File: rtl/vx_ag_tcu_fedp_seq.sv
// Operand sequencer in front of the AG-TCU fused dot-product unit: feeds one beat at a time,
// chains each FEDP result back in as the next beat's accumulator, and returns the final fp32 sum.
module vx_ag_tcu_fedp_seq #(
    parameter int N         = 1,
    parameter int XLEN      = 32,
    parameter int LATENCY   = 4,
    parameter int MAX_STEPS = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [N*XLEN-1:0]                req_a,
    input  logic [N*XLEN-1:0]                req_b,
    input  logic [XLEN-1:0]                  req_c,
    input  logic [2:0]                       req_fmt_s,
    input  logic [2:0]                       req_fmt_d,
    input  logic                             req_last,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [XLEN-1:0]                  rsp_d,
    output logic [$clog2(MAX_STEPS+1)-1:0]   rsp_steps,
    output logic                             rsp_ovf,
    output logic                             fedp_enable,
    output logic [2:0]                       fedp_fmt_s,
    output logic [2:0]                       fedp_fmt_d,
    output logic [N*XLEN-1:0]                fedp_a_row,
    output logic [N*XLEN-1:0]                fedp_b_col,
    output logic [XLEN-1:0]                  fedp_c_val,
    input  logic [XLEN-1:0]                  fedp_d_val
);

    localparam int SW = $clog2(MAX_STEPS + 1);
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    typedef enum logic [1:0] {IDLE, RUN, NEXT, RESP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [XLEN-1:0]    a_q [N];
    logic [XLEN-1:0]    a_d [N];
    logic [XLEN-1:0]    b_q [N];
    logic [XLEN-1:0]    b_d [N];
    logic [XLEN-1:0]    c_q, c_d;
    logic [2:0]         fmt_s_q, fmt_s_d;
    logic [2:0]         fmt_d_q, fmt_d_d;
    logic [SW-1:0]      steps_q, steps_d;
    logic               last_q, last_d;
    logic               ovf_q, ovf_d;
    logic [31:0]        acc_q, acc_d;
    logic               hs;

    assign hs = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            c_q     <= '0;
            fmt_s_q <= '0;
            fmt_d_q <= '0;
            steps_q <= '0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            acc_q   <= '0;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
            fmt_s_q <= fmt_s_d;
            fmt_d_q <= fmt_d_d;
            steps_q <= steps_d;
            last_q  <= last_d;
            ovf_q   <= ovf_d;
            acc_q   <= acc_d;
            for (int i = 0; i < N; i++) begin
                a_q[i] <= a_d[i];
                b_q[i] <= b_d[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, NEXT: if (req_valid) state_d = RUN;
            RUN:        if (cnt_q == '0) state_d = last_q ? RESP : NEXT;
            RESP:       if (rsp_ready) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready   = (state_q == IDLE) || (state_q == NEXT);
        rsp_valid   = (state_q == RESP);
        fedp_enable = (state_q == RUN);
    end

    always_comb begin
        cnt_d   = cnt_q;
        c_d     = c_q;
        fmt_s_d = fmt_s_q;
        fmt_d_d = fmt_d_q;
        steps_d = steps_q;
        last_d  = last_q;
        ovf_d   = ovf_q;
        acc_d   = acc_q;
        for (int i = 0; i < N; i++) begin
            a_d[i] = a_q[i];
            b_d[i] = b_q[i];
        end
        if (hs) begin
            for (int i = 0; i < N; i++) begin
                a_d[i] = req_a[i*XLEN +: XLEN];
                b_d[i] = req_b[i*XLEN +: XLEN];
            end
            cnt_d  = CW'(LATENCY);
            last_d = req_last;
            if (state_q == IDLE) begin
                c_d     = req_c;
                fmt_s_d = req_fmt_s;
                fmt_d_d = req_fmt_d;
                steps_d = SW'(1);
                ovf_d   = 1'b0;
            end else begin
                // Mid-request: chain the previous result; format stays with the first beat.
                c_d = XLEN'(acc_q);
                if (steps_q == SW'(MAX_STEPS))
                    ovf_d = 1'b1;
                else
                    steps_d = steps_q + SW'(1);
            end
        end else if (state_q == RUN) begin
            if (cnt_q != '0)
                cnt_d = cnt_q - CW'(1);
            else
                acc_d = fedp_d_val[31:0];
        end
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_lane
            assign fedp_a_row[gi*XLEN +: XLEN] = a_q[gi];
            assign fedp_b_col[gi*XLEN +: XLEN] = b_q[gi];
        end
    endgenerate

    assign fedp_c_val = c_q;
    assign fedp_fmt_s = fmt_s_q;
    assign fedp_fmt_d = fmt_d_q;
    assign rsp_d      = XLEN'(acc_q);
    assign rsp_steps  = steps_q;
    assign rsp_ovf    = ovf_q;

endmodule
